audio_stream_reader: RTL
========================

Name: audio_stream_reader

Overview:
- Parametrised successor to the single-word flash audio reader. It streams interleaved multi-channel audio words from an Avalon-MM read slave (flash/SDRAM) over a programmable address range.
- Words are prefetched into a small FIFO and delivered as one NUM_CH-wide sample frame per sample_tick from the rate divider.
- Adds forward/reverse playback, looping, abort, and underrun/done reporting. Sits between the memory controller and the audio codec output register.

Parameters:
- DATA_W, 16, width of one memory word (one channel sample)
- ADDR_W, 23, Avalon word-address width
- NUM_CH, 2, channels per frame; words are interleaved ch0,ch1,... in memory
- FIFO_DEPTH, 8, prefetch FIFO depth in words; power of 2, >= NUM_CH

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse; begins playback when idle
- stop  in  1  one-cycle pulse; aborts playback
- loop_en  in  1  1 = wrap at end of range, 0 = one-shot
- reverse  in  1  1 = play from end_addr down to start_addr
- start_addr  in  ADDR_W  first word of range (inclusive)
- end_addr  in  ADDR_W  last word of range (inclusive); end_addr >= start_addr
- sample_tick  in  1  one-cycle frame request at audio rate
- address  out  ADDR_W  Avalon read address
- read  out  1  Avalon read request
- waitrequest  in  1  Avalon stall
- readdatavalid  in  1  Avalon read data valid
- readdata  in  DATA_W  Avalon read data
- audio_sample  out  NUM_CH*DATA_W  current frame; ch0 in LSBs
- sample_valid  out  1  one-cycle pulse, new frame on audio_sample
- busy  out  1  playback active
- done  out  1  one-cycle pulse, one-shot playback finished
- underrun  out  1  one-cycle pulse, tick arrived with < NUM_CH words buffered

Behaviour:
- Reset (reset=0 at a clk edge): state IDLE; all outputs 0; FIFO empty; outstanding flag cleared. A readdatavalid arriving after reset is ignored.
- start, loop_en, reverse, start_addr and end_addr are sampled on the start pulse. start is ignored while busy. Range length (end-start+1) must be a multiple of NUM_CH; otherwise the trailing partial frame is discarded.
- Read FSM states: IDLE, REQ, WAIT_DATA, DRAIN.
  - IDLE: on start, go to REQ. busy=1. Pointer = start_addr (forward) or end_addr (reverse).
  - REQ: issue only when fifo_count + 1 <= FIFO_DEPTH. Then read=1, address=pointer. Hold both stable while waitrequest=1.
  - Acceptance is the cycle with read=1 & waitrequest=0. Next cycle: read=0, go to WAIT_DATA. Pointer steps by +1 (forward) or -1 (reverse).
  - Only one read is outstanding at a time.
  - WAIT_DATA: on readdatavalid, push readdata into the FIFO.
    - If the accepted address was the terminal address (end_addr forward, start_addr reverse) and loop_en=1: reload pointer to the range origin, go to REQ.
    - If terminal and loop_en=0: go to DRAIN.
    - Otherwise: go to REQ.
  - DRAIN: no further reads. When fifo_count < NUM_CH: discard leftovers, pulse done, busy=0, go to IDLE.
- Frame output:
  - On sample_tick with fifo_count >= NUM_CH: pop NUM_CH words. audio_sample updates and sample_valid pulses on the next cycle. The first word popped goes to ch0.
  - Latency is one clk from tick to sample_valid.
  - On sample_tick with fifo_count < NUM_CH while busy: underrun pulses next cycle; audio_sample holds its previous value; no pop.
  - Ticks while idle are ignored.
- Simultaneous push and pop in the same cycle are both performed; fifo_count = count + 1 - NUM_CH.
- A push never occurs when full, because requests are gated on free space.
- stop (any non-IDLE state):
  - If read is pending (REQ with read=1), finish that handshake first.
  - If a read is outstanding, wait for its readdatavalid and discard the data.
  - Then flush the FIFO, busy=0, go to IDLE. No done pulse.
  - stop and start in the same cycle while idle: start wins.
- Pointer arithmetic is unsigned ADDR_W. No wrap beyond the range, because the terminal check precedes the step.

Test Plan:
- Forward one-shot: NUM_CH=2, start_addr=0x10, end_addr=0x13, readdata=address-based pattern, ticks every 40 clk -> frames {0x11:0x10} then {0x13:0x12}. Then done pulses once, busy=0, and exactly 4 accepted reads.
- Waitrequest stall: hold waitrequest=1 for 10 clk on the first read -> read=1 and address=0x10 remain stable throughout; exactly one acceptance; readdatavalid 3 clk later is pushed once.
- Reverse loop: reverse=1, loop_en=1, range 0x20..0x23 -> read addresses 0x23,0x22,0x21,0x20,0x23...; first frame {0x22:0x23}; done is never asserted.
- Underrun: memory latency 30 clk per read, ticks every 20 clk -> underrun pulses; audio_sample holds its last frame; playback recovers with no words lost.
- Stop mid-read: stop while in WAIT_DATA -> the outstanding readdatavalid is absorbed; FIFO is empty; busy=0 within 1 clk of that data; no done; a new start replays from start_addr.
- Reset mid-operation: reset=0 for 1 clk during REQ with waitrequest=1 -> read=0, busy=0, all outputs 0 next cycle; a stray readdatavalid is ignored.

Source files
------------

// File: rtl/audio_stream_reader.sv
// rtl/audio_stream_reader.sv - streams interleaved multi-channel audio words from an Avalon-MM slave
// Words are prefetched one read at a time into a small FIFO and popped as NUM_CH-wide frames per sample_tick.
module audio_stream_reader #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 23,
  parameter int NUM_CH     = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     loop_en,
  input  logic                     reverse,
  input  logic [ADDR_W-1:0]        start_addr,
  input  logic [ADDR_W-1:0]        end_addr,
  input  logic                     sample_tick,
  output logic [ADDR_W-1:0]        address,
  output logic                     read,
  input  logic                     waitrequest,
  input  logic                     readdatavalid,
  input  logic [DATA_W-1:0]        readdata,
  output logic [NUM_CH*DATA_W-1:0] audio_sample,
  output logic                     sample_valid,
  output logic                     busy,
  output logic                     done,
  output logic                     underrun
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] NUM_CH_C = CNT_W'(NUM_CH);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_DATA, S_DRAIN} state_t;

  state_t                     state_q;
  logic [ADDR_W-1:0]          ptr_q;
  logic [ADDR_W-1:0]          addr_q;
  logic                       read_q;
  logic                       busy_q;
  logic                       done_q;
  logic                       underrun_q;
  logic                       sample_valid_q;
  logic [NUM_CH*DATA_W-1:0]   audio_q;
  logic                       loop_q;
  logic                       rev_q;
  logic [ADDR_W-1:0]          start_addr_q;
  logic [ADDR_W-1:0]          end_addr_q;
  logic                       term_hit_q;
  logic                       stop_q;
  logic [CNT_W-1:0]           count_q;
  logic [PTR_W-1:0]           wr_ptr_q;
  logic [PTR_W-1:0]           rd_ptr_q;
  logic [DATA_W-1:0]          mem_q [FIFO_DEPTH];

  logic                       active_c;
  logic                       can_pop_c;
  logic                       stopping_c;
  logic                       flush_c;
  logic                       push_c;
  logic                       pop_c;
  logic                       underrun_c;
  logic [CNT_W-1:0]           count_d;
  logic [NUM_CH*DATA_W-1:0]   frame_c;
  logic [ADDR_W-1:0]          term_addr_c;
  logic [ADDR_W-1:0]          origin_c;

  always_comb begin
    active_c   = (state_q != S_IDLE);
    can_pop_c  = (count_q >= NUM_CH_C);
    stopping_c = stop || stop_q;
    term_addr_c = rev_q ? start_addr_q : end_addr_q;
    origin_c    = rev_q ? end_addr_q : start_addr_q;

    // Flush happens whenever the FSM returns to IDLE from an active state.
    flush_c = 1'b0;
    case (state_q)
      S_REQ:       flush_c = stop && !read_q;
      S_WAIT_DATA: flush_c = readdatavalid && stopping_c;
      S_DRAIN:     flush_c = stop || !can_pop_c;
      default:     flush_c = 1'b0;
    endcase

    push_c     = (state_q == S_WAIT_DATA) && readdatavalid && !stopping_c;
    pop_c      = active_c && sample_tick && can_pop_c && !flush_c;
    underrun_c = active_c && sample_tick && !can_pop_c && !flush_c && (state_q != S_DRAIN);

    count_d = count_q;
    if (flush_c) begin
      count_d = '0;
    end else begin
      if (push_c) count_d = count_d + CNT_W'(1);
      if (pop_c)  count_d = count_d - NUM_CH_C;
    end

    frame_c = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      frame_c[c*DATA_W +: DATA_W] = mem_q[rd_ptr_q + PTR_W'(c)];
    end
  end

  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= readdata;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      ptr_q          <= '0;
      addr_q         <= '0;
      read_q         <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      underrun_q     <= 1'b0;
      sample_valid_q <= 1'b0;
      audio_q        <= '0;
      loop_q         <= 1'b0;
      rev_q          <= 1'b0;
      start_addr_q   <= '0;
      end_addr_q     <= '0;
      term_hit_q     <= 1'b0;
      stop_q         <= 1'b0;
      count_q        <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
    end else begin
      done_q         <= 1'b0;
      sample_valid_q <= pop_c;
      underrun_q     <= underrun_c;
      count_q        <= count_d;
      if (pop_c) audio_q <= frame_c;

      if (flush_c) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(NUM_CH);
      end

      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q      <= S_REQ;
            busy_q       <= 1'b1;
            loop_q       <= loop_en;
            rev_q        <= reverse;
            start_addr_q <= start_addr;
            end_addr_q   <= end_addr;
            ptr_q        <= reverse ? end_addr : start_addr;
            stop_q       <= 1'b0;
            term_hit_q   <= 1'b0;
          end
        end

        S_REQ: begin
          if (read_q) begin
            // A pending request must complete its handshake even if stop arrives.
            if (stop) stop_q <= 1'b1;
            if (!waitrequest) begin
              read_q     <= 1'b0;
              ptr_q      <= rev_q ? ptr_q - ADDR_W'(1) : ptr_q + ADDR_W'(1);
              term_hit_q <= (addr_q == term_addr_c);
              state_q    <= S_WAIT_DATA;
            end
          end else if (stop) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (count_q < DEPTH_C) begin
            read_q <= 1'b1;
            addr_q <= ptr_q;
          end
        end

        S_WAIT_DATA: begin
          if (readdatavalid) begin
            if (stopping_c) begin
              busy_q  <= 1'b0;
              stop_q  <= 1'b0;
              state_q <= S_IDLE;
            end else if (term_hit_q) begin
              if (loop_q) begin
                ptr_q   <= origin_c;
                state_q <= S_REQ;
              end else begin
                state_q <= S_DRAIN;
              end
            end else begin
              state_q <= S_REQ;
            end
          end else if (stop) begin
            stop_q <= 1'b1;
          end
        end

        S_DRAIN: begin
          if (stop) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (!can_pop_c) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign address      = addr_q;
  assign read         = read_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign underrun     = underrun_q;
  assign sample_valid = sample_valid_q;
  assign audio_sample = audio_q;

endmodule
